// File: rtl/c2c_arb_pkg.sv
// c2c_arb_pkg: FSM state type, parameter defaults and round-robin pick for c2c_link_arbiter
package c2c_arb_pkg;

   typedef enum logic [1:0] {IDLE, WAIT_ACK, HOLD, SEND} state_t;

   localparam int DATA_W_DEF      = 3;
   localparam int HOLD_CYC_DEF    = 100000000;
   localparam int TIMEOUT_CYC_DEF = 200000000;

   // First high bit of req at or above ptr, wrapping n-1 -> 0; result only meaningful when req is nonzero
   function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
      logic [2:0] w;
      logic       found;
      int         j;
      w     = ptr;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         j = int'(ptr) + i;
         if (j >= n) j = j - n;
         if (!found && i < n && req[j[2:0]]) begin
            w     = j[2:0];
            found = 1'b1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/c2c_link_arbiter_counter.sv
// c2c_cycle_counter: counts cycles after start; done is high in the TC-th cycle of the run
module c2c_cycle_counter #(
   parameter int TC = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic clear,
   output logic done
);

   localparam int CW = $clog2(TC + 1);

   logic [CW-1:0] cnt;
   logic          run;

   // start restarts from zero and wins over clear; the count runs until cleared
   always_ff @(posedge clk)
      if (!rst_n) begin
         run <= 1'b0;
         cnt <= '0;
      end else if (start) begin
         run <= 1'b1;
         cnt <= '0;
      end else if (clear) begin
         run <= 1'b0;
         cnt <= '0;
      end else if (run)
         cnt <= cnt + CW'(1);

   assign done = run && (cnt == CW'(TC - 1));

endmodule

// File: rtl/c2c_link_arbiter.sv
// c2c_link_arbiter: round-robin arbiter granting one requester at a time a request/ack/hold/send link
// Optional ack timeout enabled by defining C2C_ARB_TIMEOUT_EN.
module c2c_link_arbiter
   import c2c_arb_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int HOLD_CYC    = HOLD_CYC_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        grant,
   output logic [N_REQ-1:0]        done,
   output logic                    err,
   output logic                    busy,
   output logic                    request2s,
   input  logic                    ack,
   output logic [DATA_W-1:0]       data,
   output logic                    valid
);

   localparam int PW = $clog2(N_REQ);

   state_t            state, state_n;
   logic [PW-1:0]     ptr, ptr_n, win, win_n, pick, ptr_next;
   logic [N_REQ-1:0]  grant_n, done_n;
   logic              err_n, req2s_n, valid_n, hold_done, to_done;
   logic [DATA_W-1:0] data_n, win_data;

   assign pick     = PW'(rr_pick(8'(req), 3'(ptr), N_REQ));
   assign win_data = req_data[win*DATA_W +: DATA_W];
   assign ptr_next = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);

   c2c_cycle_counter #(.TC(HOLD_CYC)) u_hold (
      .clk   (clk),
      .rst_n (rst_n),
      .start (state == WAIT_ACK && ack),
      .clear (hold_done),
      .done  (hold_done)
   );

`ifdef C2C_ARB_TIMEOUT_EN
   c2c_cycle_counter #(.TC(TIMEOUT_CYC)) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .start (state == IDLE && |req),
      .clear (state == WAIT_ACK && (ack || to_done)),
      .done  (to_done)
   );
`else
   assign to_done = 1'b0;
`endif

   // State, pointer and every output are registered; reset clears all of them even mid-transfer
   always_ff @(posedge clk)
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         win       <= '0;
         grant     <= '0;
         done      <= '0;
         err       <= 1'b0;
         busy      <= 1'b0;
         request2s <= 1'b0;
         data      <= '0;
         valid     <= 1'b0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         win       <= win_n;
         grant     <= grant_n;
         done      <= done_n;
         err       <= err_n;
         busy      <= (state_n != IDLE);
         request2s <= req2s_n;
         data      <= data_n;
         valid     <= valid_n;
      end

   // Next state and next register values; data/valid default to zero outside SEND
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      win_n   = win;
      grant_n = grant;
      done_n  = '0;
      err_n   = 1'b0;
      req2s_n = request2s;
      data_n  = '0;
      valid_n = 1'b0;
      case (state)
         IDLE:
            if (|req) begin
               state_n = WAIT_ACK;
               win_n   = pick;
               grant_n = N_REQ'(1) << pick;
               req2s_n = 1'b1;
            end
         WAIT_ACK:
            if (ack) begin
               state_n = HOLD;
               req2s_n = 1'b0;
            end else if (to_done) begin
               state_n = IDLE;
               req2s_n = 1'b0;
               grant_n = '0;
               err_n   = 1'b1;
               ptr_n   = ptr_next;
            end
         HOLD:
            if (hold_done) begin
               state_n = SEND;
               data_n  = win_data;
               valid_n = 1'b1;
            end
         SEND:
            if (ack) begin
               data_n  = win_data;
               valid_n = 1'b1;
            end else begin
               state_n = IDLE;
               grant_n = '0;
               done_n  = grant;
               ptr_n   = ptr_next;
            end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_c2c_link_arbiter.sv
// tb_c2c_link_arbiter: scoreboard bench for c2c_link_arbiter; build with C2C_ARB_TIMEOUT_EN to cover the timeout
module tb_c2c_link_arbiter;

   localparam int N_REQ = 4, DATA_W = 3, HOLD_CYC = 4, TIMEOUT_CYC = 10;

   logic        clk = 1'b0, rst_n = 1'b0, ack = 1'b0;
   logic [3:0]  req = '0;
   logic [11:0] req_data = {3'b111, 3'b110, 3'b011, 3'b101};
   logic [3:0]  grant, done;
   logic        err, busy, request2s, valid;
   logic [2:0]  data;

   int          total = 0, bad = 0, hold_cnt = 0, wa_cnt = 0, sl_st = 0, sl_cnt = 0;
   logic [3:0]  prev_grant = '0;
   logic        prev_valid = 1'b0, mon_en = 1'b0, slave_en = 1'b1;

   logic [3:0]  exp_grant[$], exp_done[$];
   logic [2:0]  exp_data[$];
   logic        exp_err[$];

   c2c_link_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .HOLD_CYC(HOLD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_data  (req_data),
      .grant     (grant),
      .done      (done),
      .err       (err),
      .busy      (busy),
      .request2s (request2s),
      .ack       (ack),
      .data      (data),
      .valid     (valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_for(input int which, input string name);
      int  n   = 0;
      bit  hit = 1'b0;
      while (!hit && n < 300) begin
         @(posedge clk); #1;
         n++;
         case (which)
            0:       hit = (grant != 0);
            1:       hit = !busy;
            2:       hit = valid;
            3:       hit = busy && !request2s && !valid;
            default: hit = (done != 0);
         endcase
      end
      if (!hit) begin
         total++;
         bad++;
         $display("FAIL timeout_%s: waited %0d cycles without the event", name, n);
      end
   endtask

   task automatic xfer(input logic [3:0] r, input logic [3:0] g, input logic [2:0] d);
      exp_grant.push_back(g);
      exp_data.push_back(d);
      exp_done.push_back(g);
      req = r;
      wait_for(0, "grant");
      req = '0;
      wait_for(1, "idle");
   endtask

   // Slave: acks 2 cycles after request2s, drops ack 3 cycles after valid, forgets everything when the link idles
   initial forever begin
      @(posedge clk); #1;
      if (!slave_en) begin
         ack = 1'b0; sl_st = 0; sl_cnt = 0;
      end else if (sl_st == 0) begin
         if (!request2s) sl_cnt = 0;
         else begin
            sl_cnt++;
            if (sl_cnt == 2) begin ack = 1'b1; sl_st = 1; sl_cnt = 0; end
         end
      end else if (sl_st == 1) begin
         if (!busy) begin ack = 1'b0; sl_st = 0; sl_cnt = 0; end
         else if (valid) begin
            sl_cnt++;
            if (sl_cnt == 3) begin ack = 1'b0; sl_st = 2; sl_cnt = 0; end
         end
      end else if (!busy) sl_st = 0;
   end

   // Monitor: pops the scoreboard whenever the DUT presents a grant, payload, done or err
   always @(negedge clk) begin
      if (mon_en) begin
         if (grant != 0 && prev_grant == 0) begin
            if (exp_grant.size() != 0) chk("grant", grant, exp_grant.pop_front());
            else chk("grant_unexpected", grant, 0);
         end
         if (valid && !prev_valid) begin
            if (exp_data.size() != 0) chk("data", data, exp_data.pop_front());
            else chk("valid_unexpected", valid, 0);
            chk("hold_cycles", hold_cnt, HOLD_CYC);
         end
         if (done != 0) begin
            if (exp_done.size() != 0) chk("done", done, exp_done.pop_front());
            else chk("done_unexpected", done, 0);
         end
         if (err) begin
            if (exp_err.size() != 0) chk("err", err, exp_err.pop_front());
            else chk("err_unexpected", err, 0);
            chk("wait_ack_cycles", wa_cnt, TIMEOUT_CYC);
         end
         hold_cnt   <= (busy && !request2s && !valid) ? hold_cnt + 1 : 0;
         wa_cnt     <= request2s ? wa_cnt + 1 : 0;
         prev_grant <= grant;
         prev_valid <= valid;
      end
   end

   initial begin
      int nd = 0, n = 0, r2s_bad = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_request2s", request2s, 0);
      chk("rst_data", data, 0);
      chk("rst_valid", valid, 0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      xfer(4'b0001, 4'b0001, 3'b101);
      xfer(4'b0011, 4'b0010, 3'b011);

      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exp_grant.push_back(4'b0001 << (i % 4));
         exp_done.push_back(4'b0001 << (i % 4));
      end
      exp_data.push_back(3'b101);
      exp_data.push_back(3'b011);
      exp_data.push_back(3'b110);
      exp_data.push_back(3'b111);
      exp_data.push_back(3'b101);
      req = 4'b1111;
      while (nd < 5 && n < 500) begin
         @(posedge clk); #1;
         n++;
         if (done != 0) nd++;
      end
      req = '0;
      if (nd < 5) begin
         total++;
         bad++;
         $display("FAIL timeout_rr: got %0d done pulses, expected 5", nd);
      end
      @(posedge clk); #1;

      exp_grant.push_back(4'b0100);
      exp_data.push_back(3'b110);
      exp_done.push_back(4'b0100);
      req = 4'b0100;
      wait_for(0, "grant");
      wait_for(3, "hold");
      req = '0;
      wait_for(1, "idle");

`ifdef C2C_ARB_TIMEOUT_EN
      slave_en = 1'b0;
      exp_grant.push_back(4'b0010);
      exp_err.push_back(1'b1);
      req = 4'b0010;
      wait_for(0, "grant");
      req = '0;
      wait_for(1, "idle");
      slave_en = 1'b1;
      xfer(4'b0110, 4'b0100, 3'b110);
`else
      slave_en = 1'b0;
      exp_grant.push_back(4'b0010);
      exp_data.push_back(3'b011);
      exp_done.push_back(4'b0010);
      req = 4'b0010;
      wait_for(0, "grant");
      req = '0;
      repeat (50) begin
         @(posedge clk); #1;
         if (request2s !== 1'b1 || err !== 1'b0) r2s_bad++;
      end
      chk("no_timeout_cycles_bad", r2s_bad, 0);
      slave_en = 1'b1;
      wait_for(1, "idle");
`endif

      exp_grant.push_back(4'b0100);
      exp_data.push_back(3'b110);
      req = 4'b0100;
      wait_for(0, "grant");
      req = '0;
      wait_for(2, "valid");
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("midsend_rst_outputs", {grant, done, err, busy, request2s, data, valid}, 0);

      xfer(4'b1001, 4'b0001, 3'b101);
      xfer(4'b1000, 4'b1000, 3'b111);

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_left", exp_grant.size() + exp_data.size() + exp_done.size() + exp_err.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/c2c_link_arbiter.md
C2C_LINK_ARBITER -- requirements
Module: c2c_link_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the link; legal range 2..8.
REQ-002 Parameter DATA_W, default 3: link data width.
REQ-003 Parameter HOLD_CYC, default 100000000: cycles between ack receipt and data drive (1 s at 100 MHz); minimum 1.
REQ-004 Parameter TIMEOUT_CYC, default 200000000: maximum cycles to wait for ack.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 req  in  N_REQ  per-requester transfer request, level.
REQ-008 req_data  in  N_REQ*DATA_W  per-requester payload; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 grant  out  N_REQ  one-hot; identifies the requester owning the link.
REQ-010 done  out  N_REQ  one-cycle pulse to the requester whose transfer completed.
REQ-011 err  out  1  one-cycle pulse on ack timeout.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 request2s  out  1  link request to slave.
REQ-014 ack  in  1  slave acknowledge; synchronous to clk.
REQ-015 data  out  DATA_W  link payload to slave.
REQ-016 valid  out  1  payload valid to slave.

Function
REQ-017 FSM states: IDLE, WAIT_ACK, HOLD, SEND; all outputs registered.
REQ-018 IDLE: if any req bit is high, the next edge selects the winner, moves to WAIT_ACK, and sets grant to the winner's one-hot and request2s=1; otherwise the FSM stays in IDLE.
REQ-019 Round-robin: the winner is the first high req bit found scanning upward from the pointer, with wrap-around at N_REQ-1 -> 0; the pointer is 0 after reset.
REQ-020 WAIT_ACK: request2s stays high until ack=1; on ack=1 the next edge moves to HOLD, clears request2s, and starts the hold counter.
REQ-021 HOLD: after exactly HOLD_CYC cycles in HOLD, the next edge moves to SEND, loads data from the granted requester's req_data slice sampled on that edge, and sets valid=1.
REQ-022 SEND: data and valid are held while ack=1, and data tracks the granted slice each cycle.
REQ-023 SEND, ack=0: the next edge returns to IDLE, clears data, valid and grant, pulses done[winner], and sets the pointer to (winner+1) mod N_REQ.
REQ-024 Once a requester is granted, deasserting its req does not abort the transfer; the transfer runs to completion.
REQ-025 Back-to-back: arbitration in IDLE occurs on the cycle after a done pulse, never on the same cycle.
REQ-026 data is 0 and valid is 0 in every state except SEND.

Reset
REQ-027 On rst_n=0 at a clock edge: state=IDLE, pointer=0, counters=0, and grant, done, err, busy, request2s, data and valid all 0; this holds even mid-transfer.
REQ-028 The first arbitration after reset release occurs no earlier than the first edge with rst_n=1.

Configuration
REQ-029 Macro C2C_ARB_TIMEOUT_EN, when defined, enables the timeout function.
REQ-030 With C2C_ARB_TIMEOUT_EN defined: after TIMEOUT_CYC consecutive cycles in WAIT_ACK with ack=0, the next edge returns to IDLE, clears request2s and grant, pulses err, advances the pointer past the winner, and does not pulse done.
REQ-031 Without C2C_ARB_TIMEOUT_EN: WAIT_ACK waits indefinitely, err is tied to 0, and no timeout counter is synthesized.

Structure
REQ-032 Package c2c_arb_pkg holds the FSM state enum typedef and the default values of DATA_W, HOLD_CYC and TIMEOUT_CYC.
REQ-033 Sub-module c2c_cycle_counter, with inputs start/clear and terminal-count parameter, outputs done; it is instantiated once for HOLD and once for the timeout (the latter only with the macro defined).
REQ-034 The round-robin pick is a combinational function in the package; there is no separate module for it.

Verification (bench: HOLD_CYC=4, TIMEOUT_CYC=10, N_REQ=4)
REQ-035 Scenario 1: req=0001 with data 3'b101; slave acks 2 cycles after request2s and drops ack 3 cycles after valid -> grant=0001, valid high after exactly 4 HOLD cycles with data=101, done=0001 for one cycle, pointer=1.
REQ-036 Scenario 2: req=1111 held for 4 transfers -> grant order 0001, 0010, 0100, 1000, then 0001 again.
REQ-037 Scenario 3: req=0100 granted, then req drops during HOLD -> the transfer still completes and done=0100.
REQ-038 Scenario 4 (macro defined): req=0010 with ack held 0 -> exactly 10 WAIT_ACK cycles, err pulse, done stays 0, and the next arbitration starts at index 2.
REQ-039 Scenario 5: rst_n=0 for one cycle while in SEND -> next cycle all outputs are 0 and state is IDLE; with req=1000 afterwards, the grant goes to 1000 with the pointer back at 0.
REQ-040 Scenario 6 (macro undefined): ack held 0 for 50 cycles -> request2s stays 1 and err stays 0.
